// File: rtl/regfile_tdp_ctrl.sv
// Maps a 2-read/1-write integer register file onto one read-first true-dual-port BRAM.
// Optional post-reset array clear is built in when RF_CTRL_CLEAR_EN is defined.
module regfile_tdp_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_WORDS  = 32,
   localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  rd_valid_i,
   output logic                  rd_ready_o,
   input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rs1_data_o,
   output logic [DATA_WIDTH-1:0] rs2_data_o,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  init_done_o,
   output logic                  ram_enA_o,
   output logic                  ram_weA_o,
   output logic                  ram_enB_o,
   output logic                  ram_weB_o,
   output logic [ADDR_WIDTH-1:0] ram_addrA_o,
   output logic [ADDR_WIDTH-1:0] ram_addrB_o,
   output logic [DATA_WIDTH-1:0] ram_dataA_o,
   output logic [DATA_WIDTH-1:0] ram_dataB_o,
   input  logic [DATA_WIDTH-1:0] ram_dataA_i,
   input  logic [DATA_WIDTH-1:0] ram_dataB_i
);

   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_SPLIT = 2'd2;
`ifdef RF_CTRL_CLEAR_EN
   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_RESET = ST_CLEAR;
   localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'(NUM_WORDS / 2 - 1);
`else
   localparam logic [1:0] ST_RESET = ST_RUN;
`endif

   logic [1:0]            state_q, state_d;
   logic                  initDone_q, initDone_d;
   logic                  rspPend_q, rspPend_d;
   logic                  rspSplit_q, rspSplit_d;
   logic                  rs1Zero_q, rs1Zero_d;
   logic                  rs2Zero_q, rs2Zero_d;
   logic [ADDR_WIDTH-1:0] rs2Addr_q, rs2Addr_d;
   logic                  fwdSel_q, fwdSel_d;
   logic [DATA_WIDTH-1:0] fwdData_q, fwdData_d;
   logic [DATA_WIDTH-1:0] rs1Hold_q, rs1Hold_d;
`ifdef RF_CTRL_CLEAR_EN
   logic [ADDR_WIDTH-1:0] clrCnt_q, clrCnt_d;
`endif

   logic reqReady;
   logic rdFire;
   logic wrFire;
   logic wrReal;

   assign reqReady = initDone_q && (state_q == ST_RUN);
   assign rdFire   = rd_valid_i && reqReady;
   assign wrFire   = wr_valid_i && reqReady;
   assign wrReal   = wrFire && (wr_addr_i != '0);

   assign rd_ready_o  = reqReady;
   assign wr_ready_o  = reqReady;
   assign init_done_o = initDone_q;

   // Response is a registered pulse; a zero flag masks x0 reads and unused ports.
   assign rsp_valid_o = rspPend_q;
   assign rs1_data_o  = (rspPend_q && !rs1Zero_q) ? (rspSplit_q ? rs1Hold_q : ram_dataA_i) : '0;
   assign rs2_data_o  = (rspPend_q && !rs2Zero_q) ? ram_dataB_i : '0;

   always_comb begin
      state_d     = state_q;
`ifdef RF_CTRL_CLEAR_EN
      initDone_d  = initDone_q;
      clrCnt_d    = clrCnt_q;
`else
      initDone_d  = 1'b1;
`endif
      rspPend_d   = 1'b0;
      rspSplit_d  = 1'b0;
      rs1Zero_d   = rs1Zero_q;
      rs2Zero_d   = rs2Zero_q;
      rs2Addr_d   = rs2Addr_q;
      fwdSel_d    = fwdSel_q;
      fwdData_d   = fwdData_q;
      rs1Hold_d   = rs1Hold_q;
      ram_enA_o   = 1'b0;
      ram_weA_o   = 1'b0;
      ram_addrA_o = '0;
      ram_dataA_o = '0;
      ram_enB_o   = 1'b0;
      ram_weB_o   = 1'b0;
      ram_addrB_o = '0;
      ram_dataB_o = '0;

      case (state_q)
`ifdef RF_CTRL_CLEAR_EN
         // Gated by rst_ni so the BRAM pins stay quiet while reset is held.
         ST_CLEAR: begin
            if (rst_ni) begin
               ram_enA_o   = 1'b1;
               ram_weA_o   = 1'b1;
               ram_addrA_o = ADDR_WIDTH'({clrCnt_q, 1'b0});
               ram_enB_o   = 1'b1;
               ram_weB_o   = 1'b1;
               ram_addrB_o = ADDR_WIDTH'({clrCnt_q, 1'b1});
               if (clrCnt_q == LAST_PAIR) begin
                  state_d    = ST_RUN;
                  initDone_d = 1'b1;
               end else begin
                  clrCnt_d = clrCnt_q + ADDR_WIDTH'(1);
               end
            end
         end
`endif
         ST_RUN: begin
            if (wrReal) begin
               ram_enA_o   = 1'b1;
               ram_weA_o   = 1'b1;
               ram_addrA_o = wr_addr_i;
               ram_dataA_o = wr_data_i;
            end else if (rdFire && (rs1_addr_i != '0)) begin
               ram_enA_o   = 1'b1;
               ram_addrA_o = rs1_addr_i;
            end
            if (rdFire) begin
               rs1Zero_d = (rs1_addr_i == '0);
               rs2Zero_d = (rs2_addr_i == '0);
               // Port A is busy writing, so rs1 moves to port B and rs2 waits a cycle.
               if (wrReal) begin
                  if (rs1_addr_i != '0) begin
                     ram_enB_o   = 1'b1;
                     ram_addrB_o = rs1_addr_i;
                  end
                  rs2Addr_d = rs2_addr_i;
                  fwdSel_d  = (rs1_addr_i == wr_addr_i);
                  fwdData_d = wr_data_i;
                  state_d   = ST_SPLIT;
               end else begin
                  if (rs2_addr_i != '0) begin
                     ram_enB_o   = 1'b1;
                     ram_addrB_o = rs2_addr_i;
                  end
                  rspPend_d = 1'b1;
               end
            end
         end
         ST_SPLIT: begin
            if (!rs2Zero_q) begin
               ram_enB_o   = 1'b1;
               ram_addrB_o = rs2Addr_q;
            end
            // Read-first BRAM returned the pre-write word, hence the forwarding mux.
            rs1Hold_d  = rs1Zero_q ? '0 : (fwdSel_q ? fwdData_q : ram_dataB_i);
            rspPend_d  = 1'b1;
            rspSplit_d = 1'b1;
            state_d    = ST_RUN;
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_RESET;
         initDone_q <= 1'b0;
         rspPend_q  <= 1'b0;
         rspSplit_q <= 1'b0;
         rs1Zero_q  <= 1'b0;
         rs2Zero_q  <= 1'b0;
         rs2Addr_q  <= '0;
         fwdSel_q   <= 1'b0;
         fwdData_q  <= '0;
         rs1Hold_q  <= '0;
`ifdef RF_CTRL_CLEAR_EN
         clrCnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         initDone_q <= initDone_d;
         rspPend_q  <= rspPend_d;
         rspSplit_q <= rspSplit_d;
         rs1Zero_q  <= rs1Zero_d;
         rs2Zero_q  <= rs2Zero_d;
         rs2Addr_q  <= rs2Addr_d;
         fwdSel_q   <= fwdSel_d;
         fwdData_q  <= fwdData_d;
         rs1Hold_q  <= rs1Hold_d;
`ifdef RF_CTRL_CLEAR_EN
         clrCnt_q   <= clrCnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_tdp_ctrl.sv
// Directed and random bench for regfile_tdp_ctrl with a read-first dual-port BRAM model.
// Follows the DUT build: checks the clear sequence when RF_CTRL_CLEAR_EN is defined.
module tb_regfile_tdp_ctrl;

   localparam int DW = 32;
   localparam int NW = 32;
   localparam int AW = 5;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          rd_valid_i = 1'b0;
   logic          rd_ready_o;
   logic [AW-1:0] rs1_addr_i = '0;
   logic [AW-1:0] rs2_addr_i = '0;
   logic          rsp_valid_o;
   logic [DW-1:0] rs1_data_o;
   logic [DW-1:0] rs2_data_o;
   logic          wr_valid_i = 1'b0;
   logic          wr_ready_o;
   logic [AW-1:0] wr_addr_i = '0;
   logic [DW-1:0] wr_data_i = '0;
   logic          init_done_o;
   logic          ram_enA_o, ram_weA_o, ram_enB_o, ram_weB_o;
   logic [AW-1:0] ram_addrA_o, ram_addrB_o;
   logic [DW-1:0] ram_dataA_o, ram_dataB_o;
   logic [DW-1:0] ram_dataA_i = '0;
   logic [DW-1:0] ram_dataB_i = '0;

   regfile_tdp_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rsp_valid_o(rsp_valid_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .init_done_o(init_done_o),
      .ram_enA_o(ram_enA_o), .ram_weA_o(ram_weA_o), .ram_enB_o(ram_enB_o), .ram_weB_o(ram_weB_o),
      .ram_addrA_o(ram_addrA_o), .ram_addrB_o(ram_addrB_o),
      .ram_dataA_o(ram_dataA_o), .ram_dataB_o(ram_dataB_o),
      .ram_dataA_i(ram_dataA_i), .ram_dataB_i(ram_dataB_i)
   );

   always #5 clk_i = ~clk_i;

   // Read-first true-dual-port BRAM with registered outputs.
   logic [DW-1:0] mem [NW];
   always @(posedge clk_i) begin
      if (ram_enA_o) begin
         ram_dataA_i <= mem[ram_addrA_o];
         if (ram_weA_o) mem[ram_addrA_o] <= ram_dataA_o;
      end
      if (ram_enB_o) begin
         ram_dataB_i <= mem[ram_addrB_o];
         if (ram_weB_o) mem[ram_addrB_o] <= ram_dataB_o;
      end
   end

   int checks = 0;
   int passes = 0;
   int rdFires = 0;
   int rspSeen = 0;
   logic [DW-1:0] model [NW];
   logic          expSplit = 1'b0;
   logic          nxtV = 1'b0, latV = 1'b0;
   logic [DW-1:0] nxtD1 = '0, nxtD2 = '0, latD1 = '0, latD2 = '0;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One clock cycle: drive a request set, predict port use and response, advance, check response.
   task automatic applyStimulus(input string phase, input logic rdv, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic wrv, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd);
      logic expRdy, rdF, wrF;
      logic [DW-1:0] e1, e2;
      expRdy = !expSplit;
      checkOutput({phase, ":rd_ready"}, 128'(rd_ready_o), 128'(expRdy));
      checkOutput({phase, ":wr_ready"}, 128'(wr_ready_o), 128'(expRdy));
      rd_valid_i = rdv; rs1_addr_i = a1; rs2_addr_i = a2;
      wr_valid_i = wrv; wr_addr_i = wa; wr_data_i = wd;
      #1;
      rdF = rdv && expRdy;
      wrF = wrv && expRdy;
      if (wrF && !rdF && wa == '0)
         checkOutput({phase, ":x0_wr_quiet"}, 128'({ram_enA_o, ram_weA_o, ram_enB_o, ram_weB_o}), 128'(0));
      if (wrF && !rdF && wa != '0)
         checkOutput({phase, ":portA_wr"}, 128'({ram_enA_o, ram_weA_o, ram_weB_o, ram_addrA_o, ram_dataA_o}),
                     128'({1'b1, 1'b1, 1'b0, wa, wd}));
      if (wrF && wa != '0) model[wa] = wd;
      expSplit = rdF && wrF && (wa != '0);
      if (rdF) begin
         rdFires++;
         e1 = (a1 == '0) ? '0 : model[a1];
         e2 = (a2 == '0) ? '0 : model[a2];
         if (expSplit) begin latV = 1'b1; latD1 = e1; latD2 = e2; end
         else begin nxtV = 1'b1; nxtD1 = e1; nxtD2 = e2; end
      end
      @(posedge clk_i);
      #1;
      rd_valid_i = 1'b0;
      wr_valid_i = 1'b0;
      if (rsp_valid_o) rspSeen++;
      checkOutput({phase, ":rsp_valid"}, 128'(rsp_valid_o), 128'(nxtV));
      checkOutput({phase, ":rs1_data"}, 128'(rs1_data_o), 128'(nxtV ? nxtD1 : '0));
      checkOutput({phase, ":rs2_data"}, 128'(rs2_data_o), 128'(nxtV ? nxtD2 : '0));
      nxtV = latV; nxtD1 = latD1; nxtD2 = latD2;
      latV = 1'b0; latD1 = '0; latD2 = '0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      logic anyRdy;
      for (int i = 0; i < NW; i++) model[i] = '0;
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("reset:ready", 128'({rd_ready_o, wr_ready_o}), 128'(0));
      checkOutput("reset:init_done", 128'(init_done_o), 128'(0));
      checkOutput("reset:rsp", 128'({rsp_valid_o, rs1_data_o, rs2_data_o}), 128'(0));
      checkOutput("reset:ram", 128'({ram_enA_o, ram_weA_o, ram_enB_o, ram_weB_o, ram_addrA_o,
                                     ram_addrB_o, ram_dataA_o, ram_dataB_o}), 128'(0));
      rst_ni = 1'b1;
`ifdef RF_CTRL_CLEAR_EN
      n = 0;
      anyRdy = 1'b0;
      while (!init_done_o && n < 40) begin
         anyRdy = anyRdy | rd_ready_o | wr_ready_o;
         n++;
         @(posedge clk_i);
         #1;
      end
      checkOutput("clear:cycles", 128'(n), 128'(16));
      checkOutput("clear:ready_low", 128'(anyRdy), 128'(0));
      for (int i = 0; i < 16; i++)
         applyStimulus("clear_rd", 1'b1, AW'(2 * i + 1), AW'((2 * i + 2) % NW), 1'b0, '0, '0);
      applyStimulus("clear_drain", 1'b0, '0, '0, 1'b0, '0, '0);
`else
      n = 0;
      anyRdy = 1'b0;
      checkOutput("noclr:pre_edge", 128'({init_done_o, rd_ready_o}), 128'(0));
      @(posedge clk_i);
      #1;
      checkOutput("noclr:first_edge", 128'({init_done_o, rd_ready_o, wr_ready_o}), 128'(3'b111));
      for (int i = 1; i < NW; i++)
         applyStimulus("zero_wr", 1'b0, '0, '0, 1'b1, AW'(i), '0);
`endif
      applyStimulus("wr5", 1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
      applyStimulus("rd5", 1'b1, 5'd5, 5'd0, 1'b0, '0, '0);
      applyStimulus("rd5_idle", 1'b0, '0, '0, 1'b0, '0, '0);

      applyStimulus("col7", 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678);
      applyStimulus("col7_split", 1'b0, '0, '0, 1'b0, '0, '0);
      applyStimulus("col7_idle", 1'b0, '0, '0, 1'b0, '0, '0);

      applyStimulus("col_nofwd", 1'b1, 5'd5, 5'd9, 1'b1, 5'd9, 32'hA5A5_0F0F);
      applyStimulus("col_nofwd_split", 1'b0, '0, '0, 1'b0, '0, '0);

      applyStimulus("wr0", 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
      applyStimulus("rd0", 1'b1, 5'd0, 5'd0, 1'b0, '0, '0);
      applyStimulus("rd0_x0wr", 1'b1, 5'd7, 5'd5, 1'b1, 5'd0, 32'hFFFFFFFF);
      applyStimulus("rd0_idle", 1'b0, '0, '0, 1'b0, '0, '0);

      for (int i = 0; i < 100; i++)
         applyStimulus("rand", $urandom_range(0, 3) != 0, AW'($urandom), AW'($urandom),
                       1'($urandom), AW'($urandom_range(0, 12)), $urandom);
      applyStimulus("drain", 1'b0, '0, '0, 1'b0, '0, '0);
      applyStimulus("drain", 1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("rsp_count", 128'(rspSeen), 128'(rdFires));

      applyStimulus("rst_col", 1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 32'h0BAD_F00D);
      checkOutput("rst:split_ready", 128'(rd_ready_o), 128'(0));
      rst_ni = 1'b0;
      #1;
      checkOutput("rst:rsp", 128'({rsp_valid_o, rs1_data_o, rs2_data_o}), 128'(0));
      checkOutput("rst:ready", 128'({rd_ready_o, wr_ready_o, init_done_o}), 128'(0));
      checkOutput("rst:ram", 128'({ram_enA_o, ram_weA_o, ram_enB_o, ram_weB_o, ram_addrA_o,
                                   ram_addrB_o, ram_dataA_o, ram_dataB_o}), 128'(0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         #1;
         checkOutput("rst:no_rsp", 128'(rsp_valid_o), 128'(0));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
